// File: rtl/wb_stream_pkg.sv
// wb_stream_pkg: shared definitions for the Wishbone stream DMA engines
// (this writer and the future reader counterpart).
//   - Wishbone cycle-type (CTI) and burst-type (BTE) encodings
//   - dma_state_t: engine state enum, also exported on the debug port
package wb_stream_pkg;

  localparam logic [2:0] CTI_CLASSIC   = 3'b000;
  localparam logic [2:0] CTI_INC_BURST = 3'b010;
  localparam logic [2:0] CTI_EOB       = 3'b111;
  localparam logic [1:0] BTE_LINEAR    = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_BURST      = 2'd2
  } dma_state_t;

endpackage

// File: rtl/wb_stream_dma_adrgen.sv
// wb_stream_dma_adrgen: buffer walker shared by the stream DMA engines.
// Holds the latched buffer base, word count and current word offset, plus
// the length and beat position of the burst in progress.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          latch start_adr/nw, offset <- 0 (engine leaving IDLE)
//   start_adr     buffer base (byte address)
//   nw            buffer length in words
//   bl            clamped burst length in beats
//   burst_start   latch the current burst length, beat <- 0
//   advance       one beat completed: offset/address/beat step by one
//   wrap          together with advance: offset/address return to start
//   adr           byte address of the current beat (registered)
//   len           length of the next burst: min(bl, nw - offset)
//   last_beat     current beat is the final beat of the burst
//   end_of_buf    current beat is the last word of the buffer
module wb_stream_dma_adrgen
  import wb_stream_pkg::*;
#(
  parameter int AW  = 32,
  parameter int BPW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] start_adr,
  input  logic [AW-1:0] nw,
  input  logic [AW-1:0] bl,
  input  logic          burst_start,
  input  logic          advance,
  input  logic          wrap,
  output logic [AW-1:0] adr,
  output logic [AW-1:0] len,
  output logic          last_beat,
  output logic          end_of_buf
);

  localparam logic [AW-1:0] ONE = AW'(1);

  logic [AW-1:0] start_q;
  logic [AW-1:0] nw_q;
  logic [AW-1:0] offset_q;
  logic [AW-1:0] adr_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] beat_q;
  logic [AW-1:0] remaining;

  // Bursts are clamped so they never run past the buffer end.
  assign remaining  = nw_q - offset_q;
  assign len        = (bl < remaining) ? bl : remaining;
  assign adr        = adr_q;
  assign last_beat  = (beat_q == len_q - ONE);
  assign end_of_buf = (offset_q == nw_q - ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q  <= '0;
      nw_q     <= '0;
      offset_q <= '0;
      adr_q    <= '0;
      len_q    <= '0;
      beat_q   <= '0;
    end else if (load) begin
      start_q  <= start_adr;
      nw_q     <= nw;
      offset_q <= '0;
      adr_q    <= start_adr;
      beat_q   <= '0;
    end else begin
      if (burst_start) begin
        len_q  <= len;
        beat_q <= '0;
      end
      if (advance) begin
        beat_q <= beat_q + ONE;
        if (wrap) begin
          offset_q <= '0;
          adr_q    <= start_q;
        end else begin
          offset_q <= offset_q + ONE;
          // Address arithmetic wraps modulo 2**AW by construction.
          adr_q    <= adr_q + AW'(BPW);
        end
      end
    end
  end

endmodule

// File: rtl/wb_stream_writer_dma.sv
// wb_stream_writer_dma: Wishbone read-burst DMA that streams a circular or
// one-shot memory buffer into a downstream FIFO.
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   wbm_*                   Wishbone master (read-only incrementing bursts)
//   fifo_d, fifo_wr         write port into the stream FIFO
//   fifo_cnt                current FIFO fill level
//   enable, continuous      run request / wrap-at-end mode
//   start_adr, buf_size     buffer base and length in bytes
//   burst_size              requested beats per burst
//   busy_o, done_o, err_o   status: not idle / one-shot pass done / bus error
//   dbg_state               current engine state
//
// Bus handshake: a beat is offered while cyc&stb are high and completes on
// the edge where the slave returns ack (data accepted), err (beat and burst
// abandoned, no FIFO write) or rty (nothing completes; the same beat is
// re-offered). err takes priority over ack, ack over rty-free waiting.
module wb_stream_writer_dma
  import wb_stream_pkg::*;
#(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int FIFO_AW       = 4,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic               wbm_rty_i,
  output logic [WB_DW-1:0]   fifo_d,
  output logic               fifo_wr,
  input  logic [FIFO_AW:0]   fifo_cnt,
  input  logic               enable,
  input  logic               continuous,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [WB_AW-1:0]   buf_size,
  input  logic [WB_AW-1:0]   burst_size,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [1:0]         dbg_state
);

  localparam int BPW = WB_DW / 8;
  localparam int BSH = $clog2(BPW);
  localparam int SW  = ((WB_AW > FIFO_AW) ? WB_AW : FIFO_AW) + 2;
  localparam logic [WB_AW-1:0] MAX_BL = WB_AW'(MAX_BURST_LEN);
  localparam logic [WB_AW-1:0] ONE    = WB_AW'(1);
  localparam logic [SW-1:0]    DEPTH  = SW'(2 ** FIFO_AW);

  dma_state_t       state;
  logic             cont_q;
  logic [WB_AW-1:0] bl_q;
  logic [WB_AW-1:0] bl_in;
  logic [WB_AW-1:0] nw_in;
  logic [WB_AW-1:0] burst_len;
  logic [SW-1:0]    space_need;
  logic             space_ok;
  logic             last_beat;
  logic             end_of_buf;
  logic             load;
  logic             burst_start;
  logic             beat_ok;
  logic             advance;
  logic             wrap;

  assign nw_in = buf_size >> BSH;
  assign bl_in = (burst_size == '0)    ? ONE    :
                 (burst_size > MAX_BL) ? MAX_BL : burst_size;

  // A write issued last cycle is not yet reflected in fifo_cnt, so it is
  // reserved explicitly alongside the burst being requested.
  assign space_need = SW'(fifo_cnt) + SW'(fifo_wr) + SW'(burst_len);
  assign space_ok   = (space_need <= DEPTH);

  assign beat_ok     = wbm_ack_i && !wbm_err_i && !wbm_rty_i;
  assign load        = (state == ST_IDLE) && enable;
  assign burst_start = (state == ST_WAIT_SPACE) && enable && space_ok;
  assign advance     = (state == ST_BURST) && beat_ok;
  assign wrap        = advance && last_beat && end_of_buf && cont_q;

  wb_stream_dma_adrgen #(
    .AW  (WB_AW),
    .BPW (BPW)
  ) u_adrgen (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .load        (load),
    .start_adr   (start_adr),
    .nw          (nw_in),
    .bl          (bl_q),
    .burst_start (burst_start),
    .advance     (advance),
    .wrap        (wrap),
    .adr         (wbm_adr_o),
    .len         (burst_len),
    .last_beat   (last_beat),
    .end_of_buf  (end_of_buf)
  );

  assign wbm_dat_o = '0;
  assign wbm_we_o  = 1'b0;
  assign wbm_bte_o = BTE_LINEAR;
  assign dbg_state = state;

  // cyc is high exactly while in BURST, so the state decode alone tells
  // whether a cycle type is being presented.
  assign wbm_cti_o = (state != ST_BURST) ? CTI_CLASSIC :
                     (last_beat ? CTI_EOB : CTI_INC_BURST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      cont_q    <= 1'b0;
      bl_q      <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_sel_o <= '0;
      fifo_d    <= '0;
      fifo_wr   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      fifo_wr <= 1'b0;
      done_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state  <= ST_WAIT_SPACE;
            busy_o <= 1'b1;
            err_o  <= 1'b0;
            cont_q <= continuous;
            bl_q   <= bl_in;
          end
        end
        ST_WAIT_SPACE: begin
          if (!enable) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (space_ok) begin
            state     <= ST_BURST;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_sel_o <= '1;
          end
        end
        ST_BURST: begin
          if (wbm_err_i) begin
            state     <= ST_IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_sel_o <= '0;
            busy_o    <= 1'b0;
            err_o     <= 1'b1;
          end else if (beat_ok) begin
            fifo_wr <= 1'b1;
            fifo_d  <= wbm_dat_i;
            if (last_beat) begin
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              wbm_sel_o <= '0;
              if (end_of_buf && !cont_q) begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end else if (enable) begin
                state <= ST_WAIT_SPACE;
              end else begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
              end
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
